// File: rtl/axi_burst_mem_responder.sv
// AXI burst memory responder: single-outstanding write (AW/W/B) or read
// (AR/R) bursts against a word-addressed backing store.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_burst_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int READ_LATENCY   = 2,
    parameter int LEN_WIDTH      = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [3:0]             AWID,
    input  logic [LEN_WIDTH-1:0]   AWLEN,
    input  logic [`ADDR_WIDTH-1:0] AWADDR,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [3:0]             WID,
    input  logic [`DATA_WIDTH-1:0] WDATA,
    input  logic                   WLAST,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [3:0]             BID,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [3:0]             ARID,
    input  logic [LEN_WIDTH-1:0]   ARLEN,
    input  logic [`ADDR_WIDTH-1:0] ARADDR,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [3:0]             RID,
    output logic [`DATA_WIDTH-1:0] RDATA,
    output logic                   RLAST,
    output logic                   protocol_error
);

    typedef enum logic [2:0] {IDLE, WRITE_DATA, WRITE_RESP, READ_WAIT, READ_DATA} state_t;

    // READ_WAIT lasts READ_LATENCY-1 cycles; latencies 0 and 1 go straight to READ_DATA.
    localparam int LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int LAT_INIT = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

    logic [`DATA_WIDTH-1:0]    mem [2**MEM_ADDR_WIDTH];

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic [3:0]                id_q, id_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic                      perr_q, perr_d;
    logic                      mem_we;
    logic                      last_beat;

    // Address bits outside the word index and WID carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{WID, AWADDR[`ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], AWADDR[1:0],
                           ARADDR[`ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], ARADDR[1:0]};

    assign protocol_error = perr_q;
    assign last_beat      = (rem_q == LEN_WIDTH'(1));

    // State and transaction context registers; memory contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            lat_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            lat_q   <= lat_d;
            perr_q  <= perr_d;
        end
    end

    // Backing store write port; one word per accepted W beat.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= WDATA;
    end

    // Next-state, context updates and channel outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        id_d    = id_q;
        lat_d   = lat_q;
        perr_d  = perr_q;
        mem_we  = 1'b0;
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RLAST   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write wins a tie so a dirty-line flush lands before the refill read.
                AWREADY = AWVALID;
                ARREADY = ARVALID & ~AWVALID;
                if (AWVALID) begin
                    id_d    = AWID;
                    idx_d   = AWADDR[MEM_ADDR_WIDTH+1:2];
                    rem_d   = (AWLEN == '0) ? LEN_WIDTH'(1) : AWLEN;
                    state_d = WRITE_DATA;
                end else if (ARVALID) begin
                    id_d    = ARID;
                    idx_d   = ARADDR[MEM_ADDR_WIDTH+1:2];
                    rem_d   = (ARLEN == '0) ? LEN_WIDTH'(1) : ARLEN;
                    lat_d   = LAT_W'(LAT_INIT);
                    state_d = (READ_LATENCY <= 1) ? READ_DATA : READ_WAIT;
                end
            end
            WRITE_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    mem_we = rst_n;
                    // Beat count terminates the burst; WLAST is only checked.
                    if (WLAST != last_beat) perr_d = 1'b1;
                    idx_d = idx_q + MEM_ADDR_WIDTH'(1);
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (last_beat) state_d = WRITE_RESP;
                end
            end
            WRITE_RESP: begin
                BVALID = 1'b1;
                BID    = id_q;
                if (BREADY) state_d = IDLE;
            end
            READ_WAIT: begin
                if (lat_q == '0) state_d = READ_DATA;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            READ_DATA: begin
                RVALID = 1'b1;
                RID    = id_q;
                RDATA  = mem[idx_q];
                RLAST  = last_beat;
                if (RREADY) begin
                    idx_d = idx_q + MEM_ADDR_WIDTH'(1);
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Scoreboard bench for axi_burst_mem_responder: tasks drive directed bursts
// and queue expected B/R responses; a negedge monitor pops and compares.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_axi_burst_mem_responder;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY, RLAST, protocol_error;
    logic [3:0] AWID, WID, BID, ARID, RID;
    logic [4:0] AWLEN, ARLEN;
    logic [`ADDR_WIDTH-1:0] AWADDR, ARADDR;
    logic [`DATA_WIDTH-1:0] WDATA, RDATA;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    rbeat_t     exp_r [$];
    logic [3:0] exp_b [$];

    int vectors = 0;
    int miscompares = 0;

    axi_burst_mem_responder #(.MEM_ADDR_WIDTH(12), .READ_LATENCY(RL), .LEN_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RLAST(RLAST),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write burst of base+i data; optionally keeps ARVALID high and checks it is blocked.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [31:0] base, input int wlast_at, input bit hold_ar);
        int beats;
        beats = (len == 0) ? 1 : len;
        exp_b.push_back(id);
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len[4:0];
        @(negedge clk);
        chk("awready_same_cycle", AWREADY, 1);
        if (hold_ar) chk("arready_blocked_aw", ARREADY, 0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < beats; i++) begin
            WVALID = 1'b1; WID = id; WDATA = base + i; WLAST = (i + 1 == wlast_at);
            @(negedge clk);
            chk("wready", WREADY, 1);
            chk("bvalid_early", BVALID, 0);
            if (hold_ar) chk("arready_blocked_w", ARREADY, 0);
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        @(negedge clk);
        chk("bvalid_after_last", BVALID, 1);
        if (hold_ar) chk("arready_blocked_b", ARREADY, 0);
        @(posedge clk); #1;
    endtask

    // Read burst expecting base+i; RREADY follows pattern bit (cycle % 8) after AR.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [31:0] base, input logic [7:0] pattern);
        int beats;
        int got;
        int c;
        rbeat_t e;
        beats = (len == 0) ? 1 : len;
        for (int i = 0; i < beats; i++) begin
            e.id = id; e.data = base + i; e.last = (i == beats - 1);
            exp_r.push_back(e);
        end
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len[4:0];
        @(negedge clk);
        chk("arready", ARREADY, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        got = 0;
        c = 0;
        while (got < beats && c < 200) begin
            RREADY = pattern[c % 8];
            @(negedge clk);
            if (c < RL - 1)  chk("rvalid_latency_low", RVALID, 0);
            if (c == RL - 1) chk("rvalid_latency_high", RVALID, 1);
            if (RVALID && RREADY) got++;
            @(posedge clk); #1;
            c++;
        end
        chk("read_beat_count", got, beats);
        RREADY = 1'b1;
        @(negedge clk);
        chk("rvalid_drop_after_last", RVALID, 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops scoreboard on each handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [3:0]  prev_id;
    always @(negedge clk) begin
        rbeat_t     m;
        logic [3:0] bexp;
        if (rst_n && RVALID && prev_stall) begin
            chk("rdata_held", RDATA, prev_data);
            chk("rlast_held", RLAST, prev_last);
            chk("rid_held", RID, prev_id);
        end
        if (rst_n && RVALID && RREADY) begin
            if (exp_r.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL r_unexpected: got beat 0x%0h, expected none", RDATA);
            end else begin
                m = exp_r.pop_front();
                chk("rdata", RDATA, m.data);
                chk("rlast", RLAST, m.last);
                chk("rid", RID, m.id);
            end
        end
        if (rst_n && BVALID && BREADY) begin
            if (exp_b.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL b_unexpected: got bid 0x%0h, expected none", BID);
            end else begin
                bexp = exp_b.pop_front();
                chk("bid", BID, bexp);
            end
        end
        prev_stall = rst_n && RVALID && !RREADY;
        prev_data  = RDATA;
        prev_last  = RLAST;
        prev_id    = RID;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
        WVALID = 0; WID = 0; WDATA = 0; WLAST = 0; BREADY = 1;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_ids", {BID, RID}, 0);
        chk("rst_perr", protocol_error, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic write then read-back
        do_write(4'd3, 32'h100, 4, 32'hA0, 4, 1'b0);
        chk("perr_clean_write", protocol_error, 0);
        do_read(4'd1, 32'h100, 4, 32'hA0, 8'hFF);

        // RREADY 1,0,0,1 during the data phase
        do_read(4'd2, 32'h100, 4, 32'hA0, 8'b1111_0011);

        // Simultaneous AW/AR: write first, read returns new data
        ARVALID = 1'b1; ARID = 4'd6; ARADDR = 32'h200; ARLEN = 5'd2;
        do_write(4'd5, 32'h200, 2, 32'hC0, 2, 1'b1);
        do_read(4'd6, 32'h200, 2, 32'hC0, 8'hFF);

        // Index wrap at the top of the store
        do_write(4'd2, 32'h3FFC, 2, 32'hB0, 2, 1'b0);
        do_read(4'd7, 32'h0, 1, 32'hB1, 8'hFF);
        do_read(4'd8, 32'h1000_3FFC, 2, 32'hB0, 8'hFF);

        // LEN 0 behaves as one beat
        do_write(4'd9, 32'h400, 0, 32'hE0, 1, 1'b0);
        do_read(4'd10, 32'h400, 1, 32'hE0, 8'hFF);

        // Early WLAST: flag set and sticky, burst still four beats
        do_write(4'd11, 32'h300, 4, 32'hD0, 2, 1'b0);
        chk("perr_early_wlast", protocol_error, 1);
        do_write(4'd12, 32'h500, 1, 32'h50, 1, 1'b0);
        chk("perr_sticky", protocol_error, 1);
        do_read(4'd13, 32'h300, 4, 32'hD0, 8'hFF);

        // Reset in the middle of READ_DATA
        RREADY = 1'b0;
        ARVALID = 1'b1; ARID = 4'd14; ARADDR = 32'h100; ARLEN = 5'd4;
        @(negedge clk);
        chk("arready_pre_reset", ARREADY, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_before_reset", RVALID, 1);
        chk("rdata_before_reset", RDATA, 32'hA0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rvalid_after_reset", RVALID, 0);
        chk("rlast_after_reset", RLAST, 0);
        chk("perr_after_reset", protocol_error, 0);
        @(posedge clk); #1;
        RREADY = 1'b1;
        do_write(4'd4, 32'h600, 1, 32'hF0, 1, 1'b0);
        do_read(4'd5, 32'h600, 1, 32'hF0, 8'hFF);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("r_queue_empty", exp_r.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
